line_cmd_issuer: RTL and testbench
==================================

# line_cmd_issuer

CPU-side initiator for the line-drawing peripheral. It accepts memory-mapped writes of line endpoints and colour, and queues complete line commands in a small FIFO. It presents the commands one at a time to the Bresenham line drawer through a req/ack/done handshake, and reports queue and drawer status back to the CPU.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries (power of two, ≥2).
- CW, 9: coordinate width.
- COLW, 3: colour width.

Ports:
- clock  in  1  system clock, all logic on posedge.
- resetN  in  1  reset, synchronous, active-low.
- bus_we  in  1  write strobe, one word per cycle.
- bus_re  in  1  read strobe.
- bus_addr  in  3  word address.
- bus_wdata  in  16  write data.
- bus_rdata  out  16  read data, registered.
- draw_req  out  1  command valid to drawer.
- draw_x0, draw_y0, draw_x1, draw_y1  out  CW each  endpoints of the presented command.
- draw_color  out  COLW  colour of the presented command.
- draw_ack  in  1  drawer has captured the command.
- draw_done  in  1  single-cycle pulse when the drawer finishes the line.
- idle  out  1  FIFO empty and FSM in IDLE.

## Operation
- Staging registers X0, Y0, X1, Y1, COLOR. Writes take the low CW/COLW bits of bus_wdata. Reads return the value zero-extended.
- Register map:
  - 0 X0, 1 Y0, 2 X1, 3 Y1, 4 COLOR.
  - 5 CMD: write only, reads 0.
  - 6 STATUS.
  - 7 reserved: reads 0, writes ignored.
- CMD write behaviour:
  - wdata[0]=1 enqueues {X0,Y0,X1,Y1,COLOR}.
  - wdata[1]=1 (chain) copies X1→X0 and Y1→Y0 in the same cycle. This is for polylines.
  - The enqueued entry always uses the pre-copy values.
  - Chain applies even when the enqueue is dropped.
- STATUS read layout:
  - [0] drawer busy (FSM ≠ IDLE).
  - [1] FIFO empty.
  - [2] FIFO full.
  - [3] overflow (sticky).
  - [7:4] count.
  - Others 0.
  - Any write to STATUS clears overflow.
- FIFO rules:
  - Enqueue when full and no pop that cycle: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both are accepted and count is unchanged.
  - Count is exact, 0..DEPTH.
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop the head into the draw_* output registers and go to REQ.
  - REQ: draw_req=1 and draw_* held stable. On draw_ack go to WAIT. If draw_ack and draw_done are both high in the same cycle, go directly to IDLE.
  - WAIT: draw_req=0. On draw_done go to IDLE.
  - draw_done outside WAIT or REQ is ignored.
  - draw_ack outside REQ is ignored.
- draw_* outputs change only on a pop and keep their last value otherwise.

## Timing
- Reset values:
  - bus_rdata 0, draw_req 0, all draw_* fields 0, idle 1.
  - FIFO empty, overflow 0, staging registers 0, FSM IDLE.
- Reset mid-operation discards queued and in-flight commands. draw_req drops on the next edge.
- Read latency: bus_rdata is valid on the cycle after bus_re and holds until the next read.
- Simultaneous bus_we and bus_re: the read returns the pre-write value.
- Enqueue-to-request latency: CMD write at edge N with the FIFO empty and FSM in IDLE gives:
  - entry visible after N;
  - pop at N+1;
  - draw_req high after N+1, i.e. 2 cycles.
- Back-to-back lines: draw_done at edge M with a non-empty FIFO gives IDLE after M, pop at M+1, and draw_req high after M+1.
- Minimum REQ dwell is 1 cycle. draw_ack may be asserted in the first REQ cycle.
- idle is registered and reflects state and count after each edge.

## Structure
- Shared package holds:
  - register address constants (ADDR_X0…ADDR_STATUS);
  - STATUS bit positions;
  - FSM state encoding (IDLE, REQ, WAIT);
  - the command field layout, width 4·CW+COLW.
- One sub-module, cmd_fifo: synchronous, parameterised DEPTH/width, with push, pop, full, empty and count. Packed command word in and out.
- The top level holds the staging registers, bus decode, STATUS/overflow logic and FSM.

## Test plan
- Single line: write X0=10, Y0=20, X1=100, Y1=50, COLOR=5, CMD=1.
  - Required: draw_req rises 2 cycles after the CMD write with draw_x0=10, draw_y0=20, draw_x1=100, draw_y1=50, draw_color=5.
  - Ack after 3 cycles, done 10 cycles later → idle=1 and STATUS=0x02.
- Chain: write X0=0, Y0=0, X1=5, Y1=5, CMD=3, then X1=9, Y1=2, CMD=3.
  - Required: commands issued in order (0,0)->(5,5), then (5,5)->(9,2).
  - Final X0=9, Y0=2.
- Overflow: hold draw_ack low and enqueue 6 commands (DEPTH=4).
  - Required: 1 command is presented (popped), 4 are queued, and 1 is dropped.
  - STATUS=0x4D: busy, full, overflow, count 4.
  - A write to STATUS clears bit 3.
- Full with simultaneous pop and push: FIFO full, draw_done in WAIT, with CMD written on the pop edge.
  - Required: both are accepted, count stays 4 and overflow stays 0.
- Ack and done in the same cycle while in REQ.
  - Required: FSM returns to IDLE and the next queued command's draw_req rises 1 cycle later.
- Reset in WAIT with 2 commands queued.
  - Required: next cycle draw_req=0, STATUS=0x02, and all draw_* fields are 0.
  - A later draw_done is ignored.

Source files
------------

// File: rtl/line_cmd_issuer_pkg.sv
// +------------------------------------------------------------------+
// | line_cmd_issuer_pkg: register map, status layout, FSM, cmd fields |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package line_cmd_issuer_pkg;

    localparam logic [2:0] ADDR_X0     = 3'd0;
    localparam logic [2:0] ADDR_Y0     = 3'd1;
    localparam logic [2:0] ADDR_X1     = 3'd2;
    localparam logic [2:0] ADDR_Y1     = 3'd3;
    localparam logic [2:0] ADDR_COLOR  = 3'd4;
    localparam logic [2:0] ADDR_CMD    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int FLD_X0    = 0;
    localparam int FLD_Y0    = 1;
    localparam int FLD_X1    = 2;
    localparam int FLD_Y1    = 3;
    localparam int FLD_COLOR = 4;

    function automatic int cmd_width(input int cw, input int colw);
        return 4 * cw + colw;
    endfunction

    // Packed word is {x0, y0, x1, y1, color}, colour in the LSBs.
    function automatic int cmd_field_lsb(input int fld, input int cw, input int colw);
        return (fld == FLD_COLOR) ? 0 : colw + (3 - fld) * cw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_cmd_issuer_cmd_fifo.sv
// +------------------------------------------------------------------+
// | cmd_fifo: synchronous show-ahead FIFO with exact occupancy count  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

`default_nettype wire

// File: rtl/line_cmd_issuer.sv
// +------------------------------------------------------------------+
// | line_cmd_issuer: CPU line-command staging, queueing and issue     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module line_cmd_issuer
    import line_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 9,
    parameter int COLW  = 3
) (
    input  logic            clock,
    input  logic            resetN,
    input  logic            bus_we,
    input  logic            bus_re,
    input  logic [2:0]      bus_addr,
    input  logic [15:0]     bus_wdata,
    output logic [15:0]     bus_rdata,
    output logic            draw_req,
    output logic [CW-1:0]   draw_x0,
    output logic [CW-1:0]   draw_y0,
    output logic [CW-1:0]   draw_x1,
    output logic [CW-1:0]   draw_y1,
    output logic [COLW-1:0] draw_color,
    input  logic            draw_ack,
    input  logic            draw_done,
    output logic            idle
);

    localparam int CMDW   = cmd_width(CW, COLW);
    localparam int CNTW   = $clog2(DEPTH) + 1;
    localparam int X0_LSB = cmd_field_lsb(FLD_X0, CW, COLW);
    localparam int Y0_LSB = cmd_field_lsb(FLD_Y0, CW, COLW);
    localparam int X1_LSB = cmd_field_lsb(FLD_X1, CW, COLW);
    localparam int Y1_LSB = cmd_field_lsb(FLD_Y1, CW, COLW);
    localparam int C_LSB  = cmd_field_lsb(FLD_COLOR, CW, COLW);

    logic [CW-1:0]   x0_q, y0_q, x1_q, y1_q;
    logic [COLW-1:0] color_q;
    logic            overflow;
    state_t          state, state_nx;
    logic [CMDW-1:0] fifo_din, fifo_dout;
    logic            fifo_full, fifo_empty;
    logic [CNTW-1:0] count, count_nx;
    logic            wr_cmd, enq, push, pop;
    logic [15:0]     rd_val;
    logic            unused_wdata;

    assign unused_wdata = ^bus_wdata;

    assign wr_cmd = bus_we && (bus_addr == ADDR_CMD);
    assign enq    = wr_cmd && bus_wdata[0];
    assign pop    = (state == ST_IDLE) && !fifo_empty;
    assign push   = enq && (!fifo_full || pop);

    always_comb begin
        fifo_din                   = '0;
        fifo_din[X0_LSB +: CW]     = x0_q;
        fifo_din[Y0_LSB +: CW]     = y0_q;
        fifo_din[X1_LSB +: CW]     = x1_q;
        fifo_din[Y1_LSB +: CW]     = y1_q;
        fifo_din[C_LSB  +: COLW]   = color_q;
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMDW)
    ) u_fifo (
        .clock  (clock),
        .resetN (resetN),
        .push   (push),
        .pop    (pop),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    // Chain copies endpoint 1 into endpoint 0; the FIFO sees pre-copy values.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (bus_we) begin
            case (bus_addr)
                ADDR_X0:    x0_q    <= bus_wdata[CW-1:0];
                ADDR_Y0:    y0_q    <= bus_wdata[CW-1:0];
                ADDR_X1:    x1_q    <= bus_wdata[CW-1:0];
                ADDR_Y1:    y1_q    <= bus_wdata[CW-1:0];
                ADDR_COLOR: color_q <= bus_wdata[COLW-1:0];
                ADDR_CMD: begin
                    if (bus_wdata[1]) begin
                        x0_q <= x1_q;
                        y0_q <= y1_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            overflow <= 1'b0;
        end else if (bus_we && (bus_addr == ADDR_STATUS)) begin
            overflow <= 1'b0;
        end else if (enq && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus_addr)
            ADDR_X0:    rd_val[CW-1:0]   = x0_q;
            ADDR_Y0:    rd_val[CW-1:0]   = y0_q;
            ADDR_X1:    rd_val[CW-1:0]   = x1_q;
            ADDR_Y1:    rd_val[CW-1:0]   = y1_q;
            ADDR_COLOR: rd_val[COLW-1:0] = color_q;
            ADDR_STATUS: begin
                rd_val[STAT_BUSY]                      = (state != ST_IDLE);
                rd_val[STAT_EMPTY]                     = fifo_empty;
                rd_val[STAT_FULL]                      = fifo_full;
                rd_val[STAT_OVF]                       = overflow;
                rd_val[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(count);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            bus_rdata <= '0;
        end else if (bus_re) begin
            bus_rdata <= rd_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (draw_ack && draw_done) begin
                    state_nx = ST_IDLE;
                end else if (draw_ack) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (draw_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign draw_req = (state == ST_REQ);
    assign count_nx = count + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge clock) begin
        if (!resetN) begin
            draw_x0    <= '0;
            draw_y0    <= '0;
            draw_x1    <= '0;
            draw_y1    <= '0;
            draw_color <= '0;
            idle       <= 1'b1;
        end else begin
            if (pop) begin
                draw_x0    <= fifo_dout[X0_LSB +: CW];
                draw_y0    <= fifo_dout[Y0_LSB +: CW];
                draw_x1    <= fifo_dout[X1_LSB +: CW];
                draw_y1    <= fifo_dout[Y1_LSB +: CW];
                draw_color <= fifo_dout[C_LSB  +: COLW];
            end
            idle <= (state_nx == ST_IDLE) && (count_nx == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_cmd_issuer.sv
// +------------------------------------------------------------------+
// | tb_line_cmd_issuer: register vectors plus command scoreboard      |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_line_cmd_issuer;
    import line_cmd_issuer_pkg::*;

    localparam logic [2:0] ADDR_RSVD = 3'd7;

    logic        clock = 1'b0;
    logic        resetN;
    logic        bus_we, bus_re;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        draw_req;
    logic [8:0]  draw_x0, draw_y0, draw_x1, draw_y1;
    logic [2:0]  draw_color;
    logic        draw_ack, draw_done;
    logic        idle;

    line_cmd_issuer #(.DEPTH(4), .CW(9), .COLW(3)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .draw_req   (draw_req),
        .draw_x0    (draw_x0),
        .draw_y0    (draw_y0),
        .draw_x1    (draw_x1),
        .draw_y1    (draw_y1),
        .draw_color (draw_color),
        .draw_ack   (draw_ack),
        .draw_done  (draw_done),
        .idle       (idle)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] y0;
        logic [8:0] x1;
        logic [8:0] y1;
        logic [2:0] c;
    } cmd_t;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    cmd_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [8:0]  m_x0, m_y0, m_x1, m_y1;
    logic [2:0]  m_col;
    logic        expect_drop;
    vec_t        vecs[8];
    logic [15:0] rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clock); #1;
        bus_we = 1'b0;
        case (a)
            ADDR_X0:    m_x0  = d[8:0];
            ADDR_Y0:    m_y0  = d[8:0];
            ADDR_X1:    m_x1  = d[8:0];
            ADDR_Y1:    m_y1  = d[8:0];
            ADDR_COLOR: m_col = d[2:0];
            ADDR_CMD: begin
                if (d[0] && !expect_drop) exp_q.push_back({m_x0, m_y0, m_x1, m_y1, m_col});
                if (d[1]) begin m_x0 = m_x1; m_y0 = m_y1; end
            end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus_re = 1'b1; bus_addr = a;
        @(posedge clock); #1;
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic pulse_ack();
        draw_ack = 1'b1; @(posedge clock); #1; draw_ack = 1'b0;
    endtask

    task automatic pulse_done();
        draw_done = 1'b1; @(posedge clock); #1; draw_done = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!draw_req && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (!draw_req) begin
            n_checks++; n_fails++;
            $display("FAIL wait_req: draw_req=0 after 50 cycles, expected 1");
        end
    endtask

    task automatic serve(input int ack_wait, input int done_wait);
        wait_req();
        repeat (ack_wait) begin @(posedge clock); #1; end
        pulse_ack();
        repeat (done_wait) begin @(posedge clock); #1; end
        pulse_done();
    endtask

    // Every new request is matched against the oldest expected command.
    task automatic sb_monitor();
        logic prev = 1'b0;
        cmd_t e;
        forever begin
            @(negedge clock);
            if (draw_req && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fails++;
                    $display("FAIL sb_unexpected: request x0=%0d with no command expected", draw_x0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cmd", {draw_x0, draw_y0, draw_x1, draw_y1, draw_color}, e);
                end
            end
            prev = draw_req;
        end
    endtask

    initial begin
        vecs[0] = '{ADDR_X0,     16'hFFFF, 16'h01FF};
        vecs[1] = '{ADDR_Y0,     16'h1234, 16'h0034};
        vecs[2] = '{ADDR_X1,     16'h00AA, 16'h00AA};
        vecs[3] = '{ADDR_Y1,     16'h0100, 16'h0100};
        vecs[4] = '{ADDR_COLOR,  16'hFFFF, 16'h0007};
        vecs[5] = '{ADDR_CMD,    16'h0000, 16'h0000};
        vecs[6] = '{ADDR_STATUS, 16'hFFFF, 16'h0002};
        vecs[7] = '{ADDR_RSVD,   16'hFFFF, 16'h0000};

        resetN = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
        draw_ack = 1'b0; draw_done = 1'b0; expect_drop = 1'b0;
        m_x0 = '0; m_y0 = '0; m_x1 = '0; m_y1 = '0; m_col = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rdata", bus_rdata, 0);
        check("rst_req", draw_req, 0);
        check("rst_fields", {draw_x0, draw_y0, draw_x1, draw_y1, draw_color}, 0);
        check("rst_idle", idle, 1);
        resetN = 1'b1;
        fork sb_monitor(); join_none

        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Simultaneous write and read of X0 returns the old value.
        bus_we = 1'b1; bus_re = 1'b1; bus_addr = ADDR_X0; bus_wdata = 16'd8;
        @(posedge clock); #1;
        bus_we = 1'b0; bus_re = 1'b0; m_x0 = 9'd8;
        check("rw_old", bus_rdata, 16'h01FF);
        bus_read(ADDR_X0, rd);
        check("rw_new", rd, 8);

        // Single line and enqueue-to-request latency.
        bus_write(ADDR_X0, 10); bus_write(ADDR_Y0, 20); bus_write(ADDR_X1, 100);
        bus_write(ADDR_Y1, 50); bus_write(ADDR_COLOR, 5); bus_write(ADDR_CMD, 1);
        check("lat_req_early", draw_req, 0);
        @(posedge clock); #1;
        check("lat_req_on", draw_req, 1);
        check("single_fields", {draw_x0, draw_y0, draw_x1, draw_y1, draw_color},
              {9'd10, 9'd20, 9'd100, 9'd50, 3'd5});
        repeat (2) begin @(posedge clock); #1; end
        pulse_ack();
        repeat (9) begin @(posedge clock); #1; end
        pulse_done();
        check("single_idle", idle, 1);
        bus_read(ADDR_STATUS, rd);
        check("single_status", rd, 16'h0002);

        // Polyline chaining.
        bus_write(ADDR_X0, 0); bus_write(ADDR_Y0, 0); bus_write(ADDR_X1, 5);
        bus_write(ADDR_Y1, 5); bus_write(ADDR_CMD, 3);
        bus_write(ADDR_X1, 9); bus_write(ADDR_Y1, 2); bus_write(ADDR_CMD, 3);
        serve(0, 2);
        serve(0, 2);
        bus_read(ADDR_X0, rd);
        check("chain_x0", rd, 9);
        bus_read(ADDR_Y0, rd);
        check("chain_y0", rd, 2);

        // Overflow: one in flight, four queued, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            bus_write(ADDR_X0, 16'(30 + i));
            expect_drop = (i == 5);
            bus_write(ADDR_CMD, 1);
        end
        expect_drop = 1'b0;
        bus_read(ADDR_STATUS, rd);
        check("ovf_status", rd, 16'h004D);
        bus_write(ADDR_STATUS, 0);
        bus_read(ADDR_STATUS, rd);
        check("ovf_clear", rd, 16'h0045);

        // Full FIFO: push lands on the pop edge after draw_done.
        wait_req();
        pulse_ack();
        pulse_done();
        bus_write(ADDR_CMD, 1);
        bus_read(ADDR_STATUS, rd);
        check("full_pushpop", rd, 16'h0045);

        // Ack and done together in REQ.
        wait_req();
        draw_ack = 1'b1; draw_done = 1'b1;
        @(posedge clock); #1;
        draw_ack = 1'b0; draw_done = 1'b0;
        check("ackdone_req_low", draw_req, 0);
        @(posedge clock); #1;
        check("ackdone_req_next", draw_req, 1);

        for (int i = 0; i < 10 && !idle; i++) serve(0, 2);
        check("drain_queue", exp_q.size(), 0);
        check("drain_idle", idle, 1);
        bus_read(ADDR_STATUS, rd);
        check("drain_status", rd, 16'h0002);

        // Reset while WAIT with two queued.
        for (int i = 0; i < 3; i++) begin
            bus_write(ADDR_X0, 16'(60 + i));
            bus_write(ADDR_CMD, 1);
        end
        wait_req();
        pulse_ack();
        bus_read(ADDR_STATUS, rd);
        check("wait_status", rd, 16'h0021);
        resetN = 1'b0;
        @(posedge clock); #1;
        check("mrst_req", draw_req, 0);
        check("mrst_fields", {draw_x0, draw_y0, draw_x1, draw_y1, draw_color}, 0);
        check("mrst_idle", idle, 1);
        resetN = 1'b1;
        exp_q.delete();
        m_x0 = '0; m_y0 = '0; m_x1 = '0; m_y1 = '0; m_col = '0;
        bus_read(ADDR_STATUS, rd);
        check("mrst_status", rd, 16'h0002);
        bus_read(ADDR_X1, rd);
        check("mrst_x1", rd, 0);
        pulse_done();
        repeat (3) begin @(posedge clock); #1; end
        check("late_done_req", draw_req, 0);
        check("late_done_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
